// File: rtl/usequencer_pkg.sv
// usequencer_pkg: shared definitions for the microprogram sequencer.
//   - COND field codes used by the next-address mux.
//   - Microword field positions, computed from the width parameters.
//     Layout MSB..LSB: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, JADDR.
//   - Sequencer state encoding and NOP field values.
package usequencer_pkg;

  localparam int unsigned COND_NEXT   = 0;
  localparam int unsigned COND_N      = 1;
  localparam int unsigned COND_Z      = 2;
  localparam int unsigned COND_V      = 3;
  localparam int unsigned COND_C      = 4;
  localparam int unsigned COND_IR13   = 5;
  localparam int unsigned COND_JUMP   = 6;
  localparam int unsigned COND_DECODE = 7;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } seqState_t;

  // NOP: every field zero; C = 0 selects %r0, so nothing is written back.
  localparam int unsigned NOP_FIELD = 0;
  localparam logic        NOP_BIT   = 1'b0;

  function automatic int unsigned condLsb(input int unsigned uaddrW);
    return uaddrW;
  endfunction

  function automatic int unsigned aluLsb(input int unsigned uaddrW, input int unsigned condW);
    return uaddrW + condW;
  endfunction

  function automatic int unsigned wrPos(input int unsigned uaddrW, input int unsigned condW,
                                        input int unsigned aluW);
    return uaddrW + condW + aluW;
  endfunction

  function automatic int unsigned rdPos(input int unsigned uaddrW, input int unsigned condW,
                                        input int unsigned aluW);
    return wrPos(uaddrW, condW, aluW) + 1;
  endfunction

  function automatic int unsigned cmuxPos(input int unsigned uaddrW, input int unsigned condW,
                                          input int unsigned aluW);
    return wrPos(uaddrW, condW, aluW) + 2;
  endfunction

  function automatic int unsigned cLsb(input int unsigned uaddrW, input int unsigned condW,
                                       input int unsigned aluW);
    return wrPos(uaddrW, condW, aluW) + 3;
  endfunction

  function automatic int unsigned bmuxPos(input int unsigned uaddrW, input int unsigned condW,
                                          input int unsigned aluW, input int unsigned muxW);
    return cLsb(uaddrW, condW, aluW) + muxW;
  endfunction

  function automatic int unsigned bLsb(input int unsigned uaddrW, input int unsigned condW,
                                       input int unsigned aluW, input int unsigned muxW);
    return bmuxPos(uaddrW, condW, aluW, muxW) + 1;
  endfunction

  function automatic int unsigned amuxPos(input int unsigned uaddrW, input int unsigned condW,
                                          input int unsigned aluW, input int unsigned muxW);
    return bLsb(uaddrW, condW, aluW, muxW) + muxW;
  endfunction

  function automatic int unsigned aLsb(input int unsigned uaddrW, input int unsigned condW,
                                       input int unsigned aluW, input int unsigned muxW);
    return amuxPos(uaddrW, condW, aluW, muxW) + 1;
  endfunction

  function automatic int unsigned microWordWidth(input int unsigned uaddrW, input int unsigned condW,
                                                 input int unsigned aluW, input int unsigned muxW);
    return aLsb(uaddrW, condW, aluW, muxW) + muxW;
  endfunction

endpackage

// File: rtl/usequencer_nextaddr.sv
// usequencer_nextaddr: combinational next micro-address selection.
//   cond      COND field of the current microword
//   flags     PSR flags {N,Z,V,C}
//   ir13      IR bit 13
//   irOp      IR op, irOp3 IR op3 (used by the decode dispatch)
//   jAddr     JADDR field of the current microword
//   uPc       current micro-address
//   nextAddr  selected successor address
module usequencer_nextaddr
  import usequencer_pkg::*;
#(
  parameter int unsigned DATAWIDTH_UADDR = 11,
  parameter int unsigned DATAWIDTH_COND  = 3
) (
  input  logic [DATAWIDTH_COND-1:0]  cond,
  input  logic [3:0]                 flags,
  input  logic                       ir13,
  input  logic [1:0]                 irOp,
  input  logic [5:0]                 irOp3,
  input  logic [DATAWIDTH_UADDR-1:0] jAddr,
  input  logic [DATAWIDTH_UADDR-1:0] uPc,
  output logic [DATAWIDTH_UADDR-1:0] nextAddr
);

  logic [DATAWIDTH_UADDR-1:0] seqAddr;
  logic [DATAWIDTH_UADDR-1:0] decodeAddr;

  // Increment wraps naturally modulo 2^DATAWIDTH_UADDR.
  assign seqAddr    = uPc + DATAWIDTH_UADDR'(1);
  assign decodeAddr = DATAWIDTH_UADDR'({1'b1, irOp, irOp3, 2'b00});

  always_comb begin
    nextAddr = seqAddr;
    case (cond)
      DATAWIDTH_COND'(COND_NEXT):   nextAddr = seqAddr;
      DATAWIDTH_COND'(COND_N):      nextAddr = flags[3] ? jAddr : seqAddr;
      DATAWIDTH_COND'(COND_Z):      nextAddr = flags[2] ? jAddr : seqAddr;
      DATAWIDTH_COND'(COND_V):      nextAddr = flags[1] ? jAddr : seqAddr;
      DATAWIDTH_COND'(COND_C):      nextAddr = flags[0] ? jAddr : seqAddr;
      DATAWIDTH_COND'(COND_IR13):   nextAddr = ir13 ? jAddr : seqAddr;
      DATAWIDTH_COND'(COND_JUMP):   nextAddr = jAddr;
      DATAWIDTH_COND'(COND_DECODE): nextAddr = decodeAddr;
      default:                      nextAddr = seqAddr;
    endcase
  end

endmodule

// File: rtl/usequencer.sv
// usequencer: parametrised microprogram sequencer driving the uDataPath.
//   Clock/reset : usequencer_CLOCK_50, usequencer_Reset_InHigh (sync, active high)
//   Control store: MicroWord_In (combinational read of MicroAddr_Out)
//   Branching   : FLAGs_In {N,Z,V,C}, IR13_In, IROP_In, IROP3_In
//   Memory      : MemAck_InHigh completes a pending RD/WR
//   Stepping    : RunMode_In (1 free-run, 0 single-step), Step_InHigh
//   Datapath    : A/B/C selects, AMUX/BMUX/CMUX, RD, WR, ALU
//   Status      : Stall_OutHigh, Halted_OutHigh, Error_OutHigh (sticky timeout)
module usequencer
  import usequencer_pkg::*;
#(
  parameter int unsigned DATAWIDTH_UADDR         = 11,
  parameter int unsigned DATAWIDTH_MUX_SELECTION = 6,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
  parameter int unsigned DATAWIDTH_COND          = 3,
  parameter int unsigned UADDR_RESET             = 0,
  parameter int unsigned TIMEOUT_CYCLES          = 255
) (
  input  logic                                usequencer_CLOCK_50,
  input  logic                                usequencer_Reset_InHigh,
  input  logic [microWordWidth(DATAWIDTH_UADDR, DATAWIDTH_COND, DATAWIDTH_ALU_SELECTION,
                               DATAWIDTH_MUX_SELECTION)-1:0] usequencer_MicroWord_In,
  output logic [DATAWIDTH_UADDR-1:0]          usequencer_MicroAddr_Out,
  input  logic [3:0]                          usequencer_FLAGs_In,
  input  logic                                usequencer_IR13_In,
  input  logic [1:0]                          usequencer_IROP_In,
  input  logic [5:0]                          usequencer_IROP3_In,
  input  logic                                usequencer_MemAck_InHigh,
  input  logic                                usequencer_RunMode_In,
  input  logic                                usequencer_Step_InHigh,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]  usequencer_A_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]  usequencer_B_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]  usequencer_C_Out,
  output logic                                usequencer_AMUX_Out,
  output logic                                usequencer_BMUX_Out,
  output logic                                usequencer_CMUX_Out,
  output logic                                usequencer_RD_Out,
  output logic                                usequencer_WR_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]  usequencer_ALU_Out,
  output logic                                usequencer_Stall_OutHigh,
  output logic                                usequencer_Halted_OutHigh,
  output logic                                usequencer_Error_OutHigh
);

  localparam int unsigned UW   = DATAWIDTH_UADDR;
  localparam int unsigned CW   = DATAWIDTH_COND;
  localparam int unsigned AW   = DATAWIDTH_ALU_SELECTION;
  localparam int unsigned MX   = DATAWIDTH_MUX_SELECTION;
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);

  seqState_t       state, stateNext;
  logic [UW-1:0]   uPc, uPcNext, nextAddr;
  logic [CNTW-1:0] stallCount, stallCountNext, stallCountInc;

  logic [UW-1:0] fJAddr;
  logic [CW-1:0] fCond;
  logic [AW-1:0] fAlu;
  logic [MX-1:0] fA, fB, fC;
  logic          fAMux, fBMux, fCMux, fRd, fWr;
  logic          memBusy;

  assign fJAddr = usequencer_MicroWord_In[0 +: UW];
  assign fCond  = usequencer_MicroWord_In[condLsb(UW) +: CW];
  assign fAlu   = usequencer_MicroWord_In[aluLsb(UW, CW) +: AW];
  assign fWr    = usequencer_MicroWord_In[wrPos(UW, CW, AW)];
  assign fRd    = usequencer_MicroWord_In[rdPos(UW, CW, AW)];
  assign fCMux  = usequencer_MicroWord_In[cmuxPos(UW, CW, AW)];
  assign fC     = usequencer_MicroWord_In[cLsb(UW, CW, AW) +: MX];
  assign fBMux  = usequencer_MicroWord_In[bmuxPos(UW, CW, AW, MX)];
  assign fB     = usequencer_MicroWord_In[bLsb(UW, CW, AW, MX) +: MX];
  assign fAMux  = usequencer_MicroWord_In[amuxPos(UW, CW, AW, MX)];
  assign fA     = usequencer_MicroWord_In[aLsb(UW, CW, AW, MX) +: MX];

  assign memBusy       = (fRd | fWr) & ~usequencer_MemAck_InHigh;
  assign stallCountInc = stallCount + CNTW'(1);

  usequencer_nextaddr #(
    .DATAWIDTH_UADDR(UW),
    .DATAWIDTH_COND (CW)
  ) nextAddrMux (
    .cond    (fCond),
    .flags   (usequencer_FLAGs_In),
    .ir13    (usequencer_IR13_In),
    .irOp    (usequencer_IROP_In),
    .irOp3   (usequencer_IROP3_In),
    .jAddr   (fJAddr),
    .uPc     (uPc),
    .nextAddr(nextAddr)
  );

  always_ff @(posedge usequencer_CLOCK_50) begin
    if (usequencer_Reset_InHigh) begin
      state      <= ST_HALT;
      uPc        <= UW'(UADDR_RESET);
      stallCount <= '0;
    end else begin
      state      <= stateNext;
      uPc        <= uPcNext;
      stallCount <= stallCountNext;
    end
  end

  always_comb begin
    stateNext      = state;
    uPcNext        = uPc;
    stallCountNext = stallCount;
    case (state)
      ST_HALT: begin
        stallCountNext = '0;
        if (usequencer_RunMode_In || usequencer_Step_InHigh) stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (memBusy) begin
          // An ack on the final allowed cycle clears memBusy, so it completes instead.
          stallCountNext = stallCountInc;
          if (stallCountInc == CNTW'(TIMEOUT_CYCLES)) stateNext = ST_ERROR;
        end else begin
          uPcNext        = nextAddr;
          stallCountNext = '0;
          if (!usequencer_RunMode_In) stateNext = ST_HALT;
        end
      end
      ST_ERROR: stateNext = ST_ERROR;
      default:  stateNext = ST_HALT;
    endcase
  end

  always_comb begin
    usequencer_A_Out          = MX'(NOP_FIELD);
    usequencer_B_Out          = MX'(NOP_FIELD);
    usequencer_C_Out          = MX'(NOP_FIELD);
    usequencer_AMUX_Out       = NOP_BIT;
    usequencer_BMUX_Out       = NOP_BIT;
    usequencer_CMUX_Out       = NOP_BIT;
    usequencer_RD_Out         = NOP_BIT;
    usequencer_WR_Out         = NOP_BIT;
    usequencer_ALU_Out        = AW'(NOP_FIELD);
    usequencer_Stall_OutHigh  = 1'b0;
    usequencer_Halted_OutHigh = (state == ST_HALT);
    usequencer_Error_OutHigh  = (state == ST_ERROR);
    if (state == ST_RUN) begin
      usequencer_A_Out    = fA;
      usequencer_B_Out    = fB;
      usequencer_AMUX_Out = fAMux;
      usequencer_BMUX_Out = fBMux;
      usequencer_RD_Out   = fRd;
      usequencer_WR_Out   = fWr;
      usequencer_ALU_Out  = fAlu;
      // Register write-back is suppressed until the memory access completes.
      if (memBusy) begin
        usequencer_Stall_OutHigh = 1'b1;
      end else begin
        usequencer_C_Out    = fC;
        usequencer_CMUX_Out = fCMux;
      end
    end
  end

  assign usequencer_MicroAddr_Out = uPc;

endmodule

// File: tb/tb_usequencer.sv
module tb_usequencer;

  logic        clk;
  logic        reset;
  logic [40:0] microWord;
  logic [10:0] microAddr;
  logic [3:0]  flags;
  logic        ir13;
  logic [1:0]  irOp;
  logic [5:0]  irOp3;
  logic        memAck;
  logic        runMode;
  logic        step;
  logic [5:0]  aOut, bOut, cOut;
  logic        amuxOut, bmuxOut, cmuxOut, rdOut, wrOut;
  logic [3:0]  aluOut;
  logic        stallOut, haltedOut, errorOut;

  int checks;
  int errors;

  logic [40:0] rom [0:2047];
  assign microWord = rom[microAddr];

  usequencer #(.TIMEOUT_CYCLES(8)) dut (
    .usequencer_CLOCK_50      (clk),
    .usequencer_Reset_InHigh  (reset),
    .usequencer_MicroWord_In  (microWord),
    .usequencer_MicroAddr_Out (microAddr),
    .usequencer_FLAGs_In      (flags),
    .usequencer_IR13_In       (ir13),
    .usequencer_IROP_In       (irOp),
    .usequencer_IROP3_In      (irOp3),
    .usequencer_MemAck_InHigh (memAck),
    .usequencer_RunMode_In    (runMode),
    .usequencer_Step_InHigh   (step),
    .usequencer_A_Out         (aOut),
    .usequencer_B_Out         (bOut),
    .usequencer_C_Out         (cOut),
    .usequencer_AMUX_Out      (amuxOut),
    .usequencer_BMUX_Out      (bmuxOut),
    .usequencer_CMUX_Out      (cmuxOut),
    .usequencer_RD_Out        (rdOut),
    .usequencer_WR_Out        (wrOut),
    .usequencer_ALU_Out       (aluOut),
    .usequencer_Stall_OutHigh (stallOut),
    .usequencer_Halted_OutHigh(haltedOut),
    .usequencer_Error_OutHigh (errorOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] mkWord(input logic [5:0] a, input logic amux, input logic [5:0] b,
                                         input logic bmux, input logic [5:0] c, input logic cmux,
                                         input logic rd, input logic wr, input logic [3:0] alu,
                                         input logic [2:0] cond, input logic [10:0] jaddr);
    return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, jaddr};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearRom;
    for (int i = 0; i < 2048; i++) rom[i] = '0;
  endtask

  task automatic doReset(input logic rm);
    reset   = 1'b1;
    runMode = rm;
    step    = 1'b0;
    tick();
    reset   = 1'b0;
  endtask

  task automatic test_reset;
    clearRom();
    rom[0] = mkWord(6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 4'd3, 3'd0, 11'h000);
    memAck = 1'b0;
    doReset(1'b1);
    checks++; if (microAddr !== 11'h000) begin errors++; $display("FAIL reset addr: got %h want 000", microAddr); end
    checks++; if (haltedOut !== 1'b1) begin errors++; $display("FAIL reset halted: got %b want 1", haltedOut); end
    checks++; if ({stallOut, errorOut} !== 2'b00) begin errors++; $display("FAIL reset stall/error: got %b want 00", {stallOut, errorOut}); end
    checks++; if ({aOut, bOut, cOut, amuxOut, bmuxOut, cmuxOut, rdOut, wrOut, aluOut} !== 29'd0) begin
      errors++; $display("FAIL reset nop: got a=%0d b=%0d c=%0d alu=%0d want all 0", aOut, bOut, cOut, aluOut); end
    tick();
    checks++; if (haltedOut !== 1'b0 || microAddr !== 11'h000) begin errors++; $display("FAIL run entry: got halted=%b addr=%h want 0/000", haltedOut, microAddr); end
    checks++; if ({aOut, amuxOut, bOut, bmuxOut, cOut, cmuxOut, aluOut} !== {6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 4'd3}) begin
      errors++; $display("FAIL word fields: got a=%0d b=%0d c=%0d alu=%0d want 1/2/3/3", aOut, bOut, cOut, aluOut); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (microAddr !== 11'(i)) begin errors++; $display("FAIL sequential addr: got %h want %h", microAddr, 11'(i)); end
    end
  endtask

  task automatic test_wrap;
    clearRom();
    rom[0]     = mkWord(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd6, 11'h7FF);
    rom[11'h7FF] = mkWord(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 11'h123);
    doReset(1'b1);
    tick();
    tick();
    checks++; if (microAddr !== 11'h7FF) begin errors++; $display("FAIL jump 7ff: got %h want 7ff", microAddr); end
    tick();
    checks++; if (microAddr !== 11'h000) begin errors++; $display("FAIL wrap: got %h want 000", microAddr); end
  endtask

  typedef struct {
    logic [2:0]  cond;
    logic [3:0]  fl;
    logic        i13;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic [10:0] jaddr;
    logic [10:0] exp;
  } condVec_t;

  condVec_t cv [10];

  task automatic test_cond;
    cv[0] = '{3'd2, 4'b0100, 1'b0, 2'b00, 6'h00, 11'h040, 11'h040};
    cv[1] = '{3'd2, 4'b1011, 1'b0, 2'b00, 6'h00, 11'h040, 11'h006};
    cv[2] = '{3'd5, 4'b0000, 1'b1, 2'b00, 6'h00, 11'h040, 11'h040};
    cv[3] = '{3'd5, 4'b1111, 1'b0, 2'b00, 6'h00, 11'h040, 11'h006};
    cv[4] = '{3'd1, 4'b1000, 1'b0, 2'b00, 6'h00, 11'h040, 11'h040};
    cv[5] = '{3'd3, 4'b0010, 1'b0, 2'b00, 6'h00, 11'h040, 11'h040};
    cv[6] = '{3'd4, 4'b1110, 1'b0, 2'b00, 6'h00, 11'h040, 11'h006};
    cv[7] = '{3'd7, 4'b0000, 1'b0, 2'b10, 6'h10, 11'h040, 11'h640};
    cv[8] = '{3'd6, 4'b0000, 1'b0, 2'b00, 6'h00, 11'h7FF, 11'h7FF};
    cv[9] = '{3'd0, 4'b1111, 1'b1, 2'b00, 6'h00, 11'h040, 11'h006};
    for (int k = 0; k < 10; k++) begin
      clearRom();
      rom[0] = mkWord(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd6, 11'h005);
      rom[5] = mkWord(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, cv[k].cond, cv[k].jaddr);
      flags = cv[k].fl;
      ir13  = cv[k].i13;
      irOp  = cv[k].op;
      irOp3 = cv[k].op3;
      doReset(1'b1);
      tick();
      tick();
      checks++; if (microAddr !== 11'h005) begin errors++; $display("FAIL cond reach vec%0d: got %h want 005", k, microAddr); end
      tick();
      checks++; if (microAddr !== cv[k].exp) begin errors++; $display("FAIL cond next vec%0d: got %h want %h", k, microAddr, cv[k].exp); end
    end
  endtask

  task automatic test_stall;
    clearRom();
    rom[0] = mkWord(6'd3, 1'b0, 6'd4, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 4'd2, 3'd0, 11'h000);
    memAck = 1'b0;
    doReset(1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (stallOut !== 1'b1 || microAddr !== 11'h000) begin errors++; $display("FAIL stall cycle%0d: got stall=%b addr=%h want 1/000", i, stallOut, microAddr); end
      checks++; if ({cOut, cmuxOut, rdOut, aOut, aluOut} !== {6'd0, 1'b0, 1'b1, 6'd3, 4'd2}) begin
        errors++; $display("FAIL stall gating%0d: got c=%0d cmux=%b rd=%b a=%0d alu=%0d want 0/0/1/3/2", i, cOut, cmuxOut, rdOut, aOut, aluOut); end
      tick();
    end
    memAck = 1'b1;
    #1;
    checks++; if (stallOut !== 1'b0 || microAddr !== 11'h000) begin errors++; $display("FAIL ack cycle: got stall=%b addr=%h want 0/000", stallOut, microAddr); end
    checks++; if ({cOut, cmuxOut, rdOut} !== {6'd5, 1'b1, 1'b1}) begin errors++; $display("FAIL ack fields: got c=%0d cmux=%b rd=%b want 5/1/1", cOut, cmuxOut, rdOut); end
    tick();
    checks++; if (microAddr !== 11'h001) begin errors++; $display("FAIL post-ack addr: got %h want 001", microAddr); end
    memAck = 1'b0;
  endtask

  task automatic test_timeout;
    clearRom();
    rom[0] = mkWord(6'd2, 1'b1, 6'd0, 1'b0, 6'd7, 1'b0, 1'b0, 1'b1, 4'd5, 3'd0, 11'h000);
    memAck = 1'b0;
    doReset(1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (stallOut !== 1'b1 || errorOut !== 1'b0) begin errors++; $display("FAIL timeout stall%0d: got stall=%b err=%b want 1/0", i, stallOut, errorOut); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (errorOut !== 1'b1 || microAddr !== 11'h000) begin errors++; $display("FAIL error state%0d: got err=%b addr=%h want 1/000", i, errorOut, microAddr); end
      checks++; if ({aOut, amuxOut, wrOut, aluOut, stallOut, haltedOut} !== 15'd0) begin
        errors++; $display("FAIL error nop%0d: got a=%0d wr=%b alu=%0d stall=%b halted=%b want 0", i, aOut, wrOut, aluOut, stallOut, haltedOut); end
      tick();
    end
    doReset(1'b1);
    checks++; if (errorOut !== 1'b0 || microAddr !== 11'h000 || haltedOut !== 1'b1) begin
      errors++; $display("FAIL error reset: got err=%b addr=%h halted=%b want 0/000/1", errorOut, microAddr, haltedOut); end
    tick();
    for (int i = 0; i < 7; i++) tick();
    memAck = 1'b1;
    #1;
    checks++; if (errorOut !== 1'b0 || stallOut !== 1'b0) begin errors++; $display("FAIL ack on last: got err=%b stall=%b want 0/0", errorOut, stallOut); end
    tick();
    checks++; if (errorOut !== 1'b0 || microAddr !== 11'h001) begin errors++; $display("FAIL ack on last next: got err=%b addr=%h want 0/001", errorOut, microAddr); end
    memAck = 1'b0;
  endtask

  task automatic test_single_step;
    clearRom();
    memAck = 1'b0;
    doReset(1'b0);
    tick();
    checks++; if (haltedOut !== 1'b1 || microAddr !== 11'h000) begin errors++; $display("FAIL step idle: got halted=%b addr=%h want 1/000", haltedOut, microAddr); end
    step = 1'b1;
    tick();
    step = 1'b0;
    #1;
    checks++; if (haltedOut !== 1'b0 || microAddr !== 11'h000) begin errors++; $display("FAIL step run: got halted=%b addr=%h want 0/000", haltedOut, microAddr); end
    tick();
    checks++; if (haltedOut !== 1'b1 || microAddr !== 11'h001) begin errors++; $display("FAIL step done: got halted=%b addr=%h want 1/001", haltedOut, microAddr); end
    tick();
    checks++; if (haltedOut !== 1'b1 || microAddr !== 11'h001) begin errors++; $display("FAIL step hold: got halted=%b addr=%h want 1/001", haltedOut, microAddr); end
    step = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    step = 1'b0;
    #1;
    checks++; if (haltedOut !== 1'b1 || microAddr !== 11'h003) begin errors++; $display("FAIL step held: got halted=%b addr=%h want 1/003", haltedOut, microAddr); end
    tick();
    checks++; if (microAddr !== 11'h003) begin errors++; $display("FAIL step held after: got addr=%h want 003", microAddr); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    flags   = 4'b0000;
    ir13    = 1'b0;
    irOp    = 2'b00;
    irOp3   = 6'h00;
    memAck  = 1'b0;
    runMode = 1'b0;
    step    = 1'b0;
    clearRom();
    test_reset();
    test_wrap();
    test_cond();
    flags = 4'b0000;
    ir13  = 1'b0;
    irOp  = 2'b00;
    irOp3 = 6'h00;
    test_stall();
    test_timeout();
    test_single_step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
